// File: rtl/mmio_button_port_pkg.sv
// mmio_button_port_pkg
// Shared constants for the MMIO button/output port: memory-mapped addresses
// and button bit indices. Used by the wrapper and the VGA controller.
package mmio_button_port_pkg;

    localparam int NUM_BTN = 5;

    // Button bit positions within btn_in / the status word.
    localparam int BTN_C = 0;
    localparam int BTN_L = 1;
    localparam int BTN_R = 2;
    localparam int BTN_U = 3;
    localparam int BTN_D = 4;

    localparam logic [31:0] ADDR_BTNC_DEF   = 32'd1000;
    localparam logic [31:0] ADDR_OUT_DEF    = 32'd2000;
    localparam logic [31:0] ADDR_BTNL_DEF   = 32'd3000;
    localparam logic [31:0] ADDR_BTNR_DEF   = 32'd4000;
    localparam logic [31:0] ADDR_BTNU_DEF   = 32'd5000;
    localparam logic [31:0] ADDR_BTND_DEF   = 32'd6000;
    localparam logic [31:0] ADDR_STATUS_DEF = 32'd7000;

endpackage

// File: rtl/mmio_button_port_btn_edge_flag.sv
// btn_edge_flag
// One button: 2-flop synchronizer, previous-value flop, rising-edge detect
// and a sticky pending flag with a clear input.
// Ports:
//   clock     in   system clock
//   reset_n   in   async active-low reset
//   btn_i     in   debounced button, asynchronous to clock
//   clr_i     in   clear request (load from this button's address)
//   pending_o out  sticky press flag
module btn_edge_flag (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_i,
    input  logic clr_i,
    output logic pending_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic pending_q;
    logic pending_d;
    logic rise;

    assign rise = sync_q & ~prev_q;

    // Set has priority: the load that clears returned the old value, so a
    // press landing on the same edge must survive.
    always_comb begin
        pending_d = pending_q;
        if (clr_i) begin
            pending_d = 1'b0;
        end
        if (rise) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            meta_q    <= btn_i;
            sync_q    <= meta_q;
            prev_q    <= sync_q;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/mmio_button_port.sv
// mmio_button_port
// MMIO responder on the processor data-memory port. Loads from button
// addresses return clear-on-read press flags, the status address returns all
// flags without clearing, everything else passes through from data RAM.
// Stores to ADDR_OUT are captured with a one-cycle valid strobe and a count.
// Ports:
//   clock         in   system clock
//   reset_n       in   async active-low reset
//   btn_in[4:0]   in   debounced buttons {D,U,R,L,C}
//   address_dmem  in   processor data address
//   wren          in   processor store enable
//   data          in   processor store data
//   q_ram         in   data RAM read data
//   q_dmem        out  read data to processor
//   out_data      out  last word stored to ADDR_OUT
//   out_valid     out  one-cycle pulse after each store to ADDR_OUT
//   out_count     out  number of stores to ADDR_OUT (wraps)
module mmio_button_port
    import mmio_button_port_pkg::*;
#(
    parameter logic [31:0] ADDR_BTNC   = ADDR_BTNC_DEF,
    parameter logic [31:0] ADDR_OUT    = ADDR_OUT_DEF,
    parameter logic [31:0] ADDR_BTNL   = ADDR_BTNL_DEF,
    parameter logic [31:0] ADDR_BTNR   = ADDR_BTNR_DEF,
    parameter logic [31:0] ADDR_BTNU   = ADDR_BTNU_DEF,
    parameter logic [31:0] ADDR_BTND   = ADDR_BTND_DEF,
    parameter logic [31:0] ADDR_STATUS = ADDR_STATUS_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic [31:0]        address_dmem,
    input  logic               wren,
    input  logic [31:0]        data,
    input  logic [31:0]        q_ram,
    output logic [31:0]        q_dmem,
    output logic [31:0]        out_data,
    output logic               out_valid,
    output logic [15:0]        out_count
);

    logic [NUM_BTN-1:0] btn_hit;
    logic [NUM_BTN-1:0] btn_clr;
    logic [NUM_BTN-1:0] pending;
    logic               store_out;

    logic [31:0] out_data_q,  out_data_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_count_q, out_count_d;

    // Full 32-bit compare so nothing aliases on the low address bits.
    assign btn_hit[BTN_C] = (address_dmem == ADDR_BTNC);
    assign btn_hit[BTN_L] = (address_dmem == ADDR_BTNL);
    assign btn_hit[BTN_R] = (address_dmem == ADDR_BTNR);
    assign btn_hit[BTN_U] = (address_dmem == ADDR_BTNU);
    assign btn_hit[BTN_D] = (address_dmem == ADDR_BTND);

    // Only loads clear; stores to button addresses are ignored.
    assign btn_clr   = btn_hit & {NUM_BTN{~wren}};
    assign store_out = wren && (address_dmem == ADDR_OUT);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_edge_flag u_flag (
            .clock     (clock),
            .reset_n   (reset_n),
            .btn_i     (btn_in[i]),
            .clr_i     (btn_clr[i]),
            .pending_o (pending[i])
        );
    end

    // btn_clr is at most one-hot, so OR-reducing the masked flags selects it.
    always_comb begin
        q_dmem = q_ram;
        if (|btn_clr) begin
            q_dmem = {31'b0, |(btn_clr & pending)};
        end else if (address_dmem == ADDR_STATUS) begin
            q_dmem = {{(32-NUM_BTN){1'b0}}, pending};
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_count_d = out_count_q;
        if (store_out) begin
            out_data_d  = data;
            out_valid_d = 1'b1;
            out_count_d = out_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_mmio_button_port.sv
module tb_mmio_button_port;

    logic        clock;
    logic        reset_n;
    logic [4:0]  btn_in;
    logic [31:0] address_dmem;
    logic        wren;
    logic [31:0] data;
    logic [31:0] q_ram;
    logic [31:0] q_dmem;
    logic [31:0] out_data;
    logic        out_valid;
    logic [15:0] out_count;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] RAM_WORD = 32'hCAFE_0001;
    localparam logic [31:0] IDLE     = 32'd8;

    mmio_button_port dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .btn_in       (btn_in),
        .address_dmem (address_dmem),
        .wren         (wren),
        .data         (data),
        .q_ram        (q_ram),
        .q_dmem       (q_dmem),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_count    (out_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a load address and let the combinational read settle.
    task automatic load(input logic [31:0] a);
        address_dmem = a;
        wren         = 1'b0;
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        btn_in       = 5'b0;
        address_dmem = 32'd1000;
        wren         = 1'b0;
        data         = 32'h0;
        q_ram        = RAM_WORD;
        #2;
        check("rst_btnc_load", q_dmem, 32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_count", {16'b0, out_count}, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;

        load(32'd1000);
        check("load_btnc_idle", q_dmem, 32'h0);
        load(IDLE);
        check("load_ram", q_dmem, RAM_WORD);
        load(32'd1000 + 32'd4096);
        check("no_alias", q_dmem, RAM_WORD);
        load(IDLE);
        tick();

        // Centre button: 5-cycle pulse, wait 3, then two loads.
        btn_in[0] = 1'b1;
        repeat (5) tick();
        btn_in[0] = 1'b0;
        repeat (3) tick();
        load(32'd1000);
        check("btnc_first_load", q_dmem, 32'h1);
        tick();
        load(32'd1000);
        check("btnc_second_load", q_dmem, 32'h0);
        tick();
        load(IDLE);

        // L and U together; status is non-destructive.
        btn_in[1] = 1'b1;
        btn_in[3] = 1'b1;
        repeat (4) tick();
        load(32'd7000);
        check("status_lu", q_dmem, 32'h0A);
        tick();
        load(32'd7000);
        check("status_lu_again", q_dmem, 32'h0A);
        load(32'd3000);
        check("btnl_load", q_dmem, 32'h1);
        tick();
        load(32'd7000);
        check("status_after_l", q_dmem, 32'h08);
        // Buttons still held: no auto-repeat.
        load(IDLE);
        repeat (3) tick();
        load(32'd7000);
        check("held_no_repeat", q_dmem, 32'h08);
        load(32'd5000);
        tick();
        btn_in = 5'b0;
        load(32'd7000);
        check("status_cleared", q_dmem, 32'h00);
        load(IDLE);
        tick();

        // Down button: set lands on the same edge as a load from 6000.
        btn_in[4] = 1'b1;          // before edge N
        tick();                    // N
        tick();                    // N+1
        load(32'd6000);
        check("btnd_same_edge_old", q_dmem, 32'h0);
        tick();                    // N+2: clear and set collide, set wins
        check("btnd_set_wins", q_dmem, 32'h1);
        tick();
        check("btnd_cleared", q_dmem, 32'h0);
        btn_in[4] = 1'b0;
        load(IDLE);
        tick();

        // Back-to-back stores to ADDR_OUT.
        address_dmem = 32'd2000;
        wren         = 1'b1;
        data         = 32'hDEAD_BEEF;
        tick();
        check("st1_valid", {31'b0, out_valid}, 32'h1);
        check("st1_data", out_data, 32'hDEAD_BEEF);
        check("st1_count", {16'b0, out_count}, 32'h1);
        data = 32'h1234_5678;
        tick();
        check("st2_valid", {31'b0, out_valid}, 32'h1);
        check("st2_data", out_data, 32'h1234_5678);
        check("st2_count", {16'b0, out_count}, 32'h2);
        address_dmem = 32'd1000;
        data         = 32'h5555_AAAA;
        tick();
        check("st_btn_valid", {31'b0, out_valid}, 32'h0);
        check("st_btn_count", {16'b0, out_count}, 32'h2);
        check("st_btn_data_hold", out_data, 32'h1234_5678);
        load(IDLE);
        tick();

        // All five pressed; a store to a button address must not clear.
        btn_in = 5'h1F;
        repeat (4) tick();
        load(32'd7000);
        check("status_all", q_dmem, 32'h1F);
        address_dmem = 32'd1000;
        wren         = 1'b1;
        tick();
        load(32'd7000);
        check("store_no_clear", q_dmem, 32'h1F);
        address_dmem = 32'd2000;
        wren         = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data = 32'h100 + k;
            tick();
        end
        check("pre_rst_count", {16'b0, out_count}, 32'h5);
        check("pre_rst_valid", {31'b0, out_valid}, 32'h1);

        // Asynchronous reset mid-cycle, no edge in between.
        #2;
        reset_n      = 1'b0;
        address_dmem = 32'd7000;
        wren         = 1'b0;
        #1;
        check("arst_status", q_dmem, 32'h0);
        check("arst_count", {16'b0, out_count}, 32'h0);
        check("arst_data", out_data, 32'h0);
        check("arst_valid", {31'b0, out_valid}, 32'h0);

        // Release while all buttons held: fresh rise once synchronizer fills.
        tick();
        #2;
        reset_n = 1'b1;
        tick();
        tick();
        check("rel_not_yet", q_dmem, 32'h00);
        address_dmem = IDLE;
        tick();
        load(32'd7000);
        check("rel_fresh_rise", q_dmem, 32'h1F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmio_button_port.md
# mmio_button_port

Memory-mapped I/O responder between the processor's data-memory port and the board peripherals. It serves processor loads from the button addresses with sticky, clear-on-read press flags, and passes all other loads through from data RAM. It also captures processor stores to the output address into a register with a one-cycle valid strobe for the VGA side. It replaces the ad-hoc combinational address decode in the top-level wrapper.

## Interface

Parameters:
- ADDR_BTNC, 1000, load address for centre-button flag
- ADDR_OUT, 2000, store address for processor output word
- ADDR_BTNL, 3000, left-button flag
- ADDR_BTNR, 4000, right-button flag
- ADDR_BTNU, 5000, up-button flag
- ADDR_BTND, 6000, down-button flag
- ADDR_STATUS, 7000, non-destructive read of all five flags

Ports:
- clock  in  1  single system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- btn_in  in  5  debounced buttons {D,U,R,L,C} = bits [4:0], asynchronous to clock
- address_dmem  in  32  processor data address
- wren  in  1  processor store enable
- data  in  32  processor store data
- q_ram  in  32  read data from data RAM
- q_dmem  out  32  read data returned to processor
- out_data  out  32  last word stored to ADDR_OUT
- out_valid  out  1  one-cycle pulse after each store to ADDR_OUT
- out_count  out  16  number of stores to ADDR_OUT, wraps

## Operation

- Input path per button: 2-flop synchronizer -> previous-value flop -> rising-edge detect `rise = sync & ~prev`.
- pending[i] set on rise[i]; cleared on a rising edge where `address_dmem == ADDR_BTN(i)` and `wren == 0`.
- Same-cycle set and clear: set wins. The load returned the old value, so the new press is not lost.
- Held button produces exactly one rise; no auto-repeat.
- Read mux, combinational:
  - `address_dmem == ADDR_BTN(i)` and `!wren`: q_dmem = {31'b0, pending[i]}.
  - ADDR_STATUS: q_dmem = {27'b0, pending}; no clear.
  - Otherwise: q_dmem = q_ram.
- Store to ADDR_OUT (`wren == 1`):
  - out_data <= data, out_valid <= 1 for exactly one cycle, out_count <= out_count + 1 (mod 2^16).
  - Back-to-back stores give consecutive valid pulses, each with its own data.
- Stores to button or status addresses are ignored and do not clear flags.
- Only the full 32-bit address matches; no aliasing on the low 12 bits.

## Timing

- Reset, asynchronous: synchronizers, prev, pending, out_data, out_valid, out_count all 0. q_dmem therefore follows q_ram, or 0 for button addresses.
- Press latency: btn_in rising before clock edge N is synchronized at N+1, rise is high in cycle N+1, and pending is set at edge N+2. It is visible to a load from edge N+2 onward.
- Read data has zero latency, combinational from address. The clear takes effect at the end of the load cycle.
- Releasing reset_n mid-press: the button is seen as a fresh rise once the synchronizer fills.
- A load must present its address for exactly one cycle. The processor MEM stage guarantees this; a longer hold clears on the first edge.

## Structure

- Shared package holds the address constants and button index constants (BTN_C=0 … BTN_D=4) used by the wrapper and the VGA controller.
- One natural sub-module: `btn_edge_flag`, one instance per button, containing the synchronizer, edge detect and pending flop with set/clear inputs.
- Top level holds the address decode, read mux and output register.

## Test plan

- Reset, then a load from 1000 -> q_dmem = 0; a load from 8 -> q_dmem = q_ram.
- Pulse btn_in[0] high for 5 cycles, wait 3 cycles, load 1000 -> 1. Load 1000 again the next cycle -> 0.
- Press L and U together, load 7000 -> 0x0A with flags unchanged. Load 3000 -> 1, then 7000 -> 0x08.
- Rise on btn_in[4] timed so the pending set lands on the same edge as a load from 6000. The load returns 0 and the following load returns 1.
- Store 0xDEADBEEF then 0x12345678 to 2000 on consecutive cycles -> out_valid high for two cycles, out_data follows, out_count = 2. A store to 1000 leaves out_count unchanged.
- Assert reset_n low mid-operation with pending = 0x1F and out_count = 5 -> all outputs return to 0 immediately, with no clock edge required.
